// File: rtl/alu_operand_pkg.sv
// Shared encodings, default widths and immediate-extension helper for the
// ALU operand-select stage.
package alu_operand_pkg;

    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned IMM_W_DEF  = 8;
    localparam int unsigned JMP_W_DEF  = 12;
    localparam int unsigned RA_W_DEF   = 4;
    localparam int unsigned PC_INC_DEF = 2;

    // Working width of ext_imm; callers truncate to their datapath width.
    localparam int unsigned EXT_W = 32;

    typedef enum logic [1:0] {
        SRCA_PC   = 2'd0,
        SRCA_RS1  = 2'd1,
        SRCA_ZERO = 2'd2,
        SRCA_RSVD = 2'd3
    } srca_e;

    typedef enum logic [2:0] {
        SRCB_RS2     = 3'd0,
        SRCB_INC     = 3'd1,
        SRCB_SEXT    = 3'd2,
        SRCB_ZEXT    = 3'd3,
        SRCB_SEXT_S1 = 3'd4,
        SRCB_JSEXT   = 3'd5,
        SRCB_RSVD6   = 3'd6,
        SRCB_RSVD7   = 3'd7
    } srcb_e;

    // Immediate/constant operand for SrcB. RS2 and reserved modes yield zero;
    // the caller supplies RS2 itself. Sign extension works at EXT_W, so
    // truncating the result to any width <= EXT_W stays correct, and the
    // MSB dropped by SEXT<<1 falls out of that truncation.
    function automatic logic [EXT_W-1:0] ext_imm(
        input srcb_e              mode,
        input logic [EXT_W-1:0]   imm,
        input logic [EXT_W-1:0]   jimm,
        input int unsigned        imm_w = IMM_W_DEF,
        input int unsigned        jmp_w = JMP_W_DEF,
        input logic [EXT_W-1:0]   inc   = EXT_W'(PC_INC_DEF)
    );
        logic signed [EXT_W-1:0] s_imm;
        logic signed [EXT_W-1:0] s_jimm;
        logic [EXT_W-1:0]        res;
        s_imm  = $signed(imm  << (EXT_W - imm_w)) >>> (EXT_W - imm_w);
        s_jimm = $signed(jimm << (EXT_W - jmp_w)) >>> (EXT_W - jmp_w);
        res    = '0;
        case (mode)
            SRCB_INC:     res = inc;
            SRCB_SEXT:    res = s_imm;
            SRCB_ZEXT:    res = imm;
            SRCB_SEXT_S1: res = s_imm << 1;
            SRCB_JSEXT:   res = s_jimm;
            default:      res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/operand_forward.sv
// RAW-hazard bypass for one source register: EX/MEM beats MEM/WB beats the
// register file; register 0 is never bypassed.
module operand_forward
    import alu_operand_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs_addr_i,
    input  logic [DW-1:0]   rf_data_i,
    input  logic            exmem_wr_i,
    input  logic [RA_W-1:0] exmem_addr_i,
    input  logic [DW-1:0]   exmem_data_i,
    input  logic            memwb_wr_i,
    input  logic [RA_W-1:0] memwb_addr_i,
    input  logic [DW-1:0]   memwb_data_i,
    output logic [DW-1:0]   fwd_data_o
);

    // Priority select between the two bypass ports and register-file data.
    always_comb begin
        fwd_data_o = rf_data_i;
        if (rs_addr_i != '0) begin
            if (exmem_wr_i && (exmem_addr_i == rs_addr_i)) begin
                fwd_data_o = exmem_data_i;
            end else if (memwb_wr_i && (memwb_addr_i == rs_addr_i)) begin
                fwd_data_o = memwb_data_i;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-select stage: forwards RS1/RS2, muxes ALU sources A/B and latches
// them into a one-entry valid/ready output register with flush support.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned IMM_W  = IMM_W_DEF,
    parameter int unsigned JMP_W  = JMP_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF,
    parameter int unsigned PC_INC = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [DW-1:0]    PC,
    input  logic [DW-1:0]    D_Rs1,
    input  logic [DW-1:0]    D_Rs2,
    input  logic [RA_W-1:0]  C_Rs1_Addr,
    input  logic [RA_W-1:0]  C_Rs2_Addr,
    input  logic [IMM_W-1:0] D_Imm,
    input  logic [JMP_W-1:0] D_JImm,
    input  logic [1:0]       C_SrcA,
    input  logic [2:0]       C_SrcB,
    input  logic             F_ExMem_Wr,
    input  logic             F_MemWb_Wr,
    input  logic [RA_W-1:0]  F_ExMem_Addr,
    input  logic [RA_W-1:0]  F_MemWb_Addr,
    input  logic [DW-1:0]    F_ExMem_Data,
    input  logic [DW-1:0]    F_MemWb_Data,
    output logic [DW-1:0]    ALU_A,
    output logic [DW-1:0]    ALU_B,
    output logic [DW-1:0]    Store_Data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [DW-1:0] rs1_fwd;
    logic [DW-1:0] rs2_fwd;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          accept;

    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [DW-1:0] store_q, store_d;
    logic          valid_q, valid_d;

    operand_forward #(.DW(DW), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr_i    (C_Rs1_Addr),
        .rf_data_i    (D_Rs1),
        .exmem_wr_i   (F_ExMem_Wr),
        .exmem_addr_i (F_ExMem_Addr),
        .exmem_data_i (F_ExMem_Data),
        .memwb_wr_i   (F_MemWb_Wr),
        .memwb_addr_i (F_MemWb_Addr),
        .memwb_data_i (F_MemWb_Data),
        .fwd_data_o   (rs1_fwd)
    );

    operand_forward #(.DW(DW), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr_i    (C_Rs2_Addr),
        .rf_data_i    (D_Rs2),
        .exmem_wr_i   (F_ExMem_Wr),
        .exmem_addr_i (F_ExMem_Addr),
        .exmem_data_i (F_ExMem_Data),
        .memwb_wr_i   (F_MemWb_Wr),
        .memwb_addr_i (F_MemWb_Addr),
        .memwb_data_i (F_MemWb_Data),
        .fwd_data_o   (rs2_fwd)
    );

    // Source A/B operand multiplexers.
    always_comb begin
        src_a = '0;
        case (srca_e'(C_SrcA))
            SRCA_PC:  src_a = PC;
            SRCA_RS1: src_a = rs1_fwd;
            default:  src_a = '0;
        endcase
        if (srcb_e'(C_SrcB) == SRCB_RS2) begin
            src_b = rs2_fwd;
        end else begin
            src_b = DW'(ext_imm(srcb_e'(C_SrcB), EXT_W'(D_Imm), EXT_W'(D_JImm),
                                IMM_W, JMP_W, EXT_W'(PC_INC)));
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Output-register next state: flush, then accept, then drain on consume.
    always_comb begin
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        store_d = store_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            alu_a_d = src_a;
            alu_b_d = src_b;
            store_d = rs2_fwd;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            store_q <= '0;
            valid_q <= 1'b0;
        end else begin
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            store_q <= store_d;
            valid_q <= valid_d;
        end
    end

    assign ALU_A      = alu_a_q;
    assign ALU_B      = alu_b_q;
    assign Store_Data = store_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush;
    logic [15:0] PC, D_Rs1, D_Rs2;
    logic [3:0]  C_Rs1_Addr, C_Rs2_Addr;
    logic [7:0]  D_Imm;
    logic [11:0] D_JImm;
    logic [1:0]  C_SrcA;
    logic [2:0]  C_SrcB;
    logic        F_ExMem_Wr, F_MemWb_Wr;
    logic [3:0]  F_ExMem_Addr, F_MemWb_Addr;
    logic [15:0] F_ExMem_Data, F_MemWb_Data;
    logic [15:0] ALU_A, ALU_B, Store_Data;
    logic        out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DW(16), .IMM_W(8), .JMP_W(12), .RA_W(4), .PC_INC(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .PC(PC), .D_Rs1(D_Rs1), .D_Rs2(D_Rs2),
        .C_Rs1_Addr(C_Rs1_Addr), .C_Rs2_Addr(C_Rs2_Addr),
        .D_Imm(D_Imm), .D_JImm(D_JImm), .C_SrcA(C_SrcA), .C_SrcB(C_SrcB),
        .F_ExMem_Wr(F_ExMem_Wr), .F_MemWb_Wr(F_MemWb_Wr),
        .F_ExMem_Addr(F_ExMem_Addr), .F_MemWb_Addr(F_MemWb_Addr),
        .F_ExMem_Data(F_ExMem_Data), .F_MemWb_Data(F_MemWb_Data),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .Store_Data(Store_Data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        PC = '0; D_Rs1 = '0; D_Rs2 = '0; C_Rs1_Addr = '0; C_Rs2_Addr = '0;
        D_Imm = '0; D_JImm = '0; C_SrcA = 2'd2; C_SrcB = 3'd6;
        F_ExMem_Wr = 1'b0; F_MemWb_Wr = 1'b0; F_ExMem_Addr = '0; F_MemWb_Addr = '0;
        F_ExMem_Data = '0; F_MemWb_Data = '0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (ALU_A !== 16'h0000) begin bad++; $display("FAIL reset_a got=%h exp=0000", ALU_A); end
        total++; if (ALU_B !== 16'h0000) begin bad++; $display("FAIL reset_b got=%h exp=0000", ALU_B); end
        total++; if (Store_Data !== 16'h0000) begin bad++; $display("FAIL reset_store got=%h exp=0000", Store_Data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_pc_inc();
        set_idle();
        C_SrcA = 2'd0; C_SrcB = 3'd1; PC = 16'h0100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inc_valid got=%b exp=1", out_valid); end
        total++; if (ALU_A !== 16'h0100) begin bad++; $display("FAIL inc_a got=%h exp=0100", ALU_A); end
        total++; if (ALU_B !== 16'h0002) begin bad++; $display("FAIL inc_b got=%h exp=0002", ALU_B); end
        PC = 16'h7777;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        total++; if (ALU_A !== 16'h0100) begin bad++; $display("FAIL drain_hold_a got=%h exp=0100", ALU_A); end
    endtask

    // Back-to-back immediate modes; each vector accepted on consecutive edges.
    task automatic test_ext_modes();
        logic [2:0]  mode [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd4, 3'd6, 3'd0};
        logic [7:0]  imm  [8] = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h7F, 8'hC0, 8'hFF, 8'hFF};
        logic [11:0] jimm [8] = '{12'h000, 12'h000, 12'h000, 12'h800, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        logic [15:0] expb [8] = '{16'hFF80, 16'h0080, 16'hFF00, 16'hF800, 16'h007F, 16'hFF80, 16'h0000, 16'h1234};
        set_idle();
        D_Rs2 = 16'h1234; C_Rs2_Addr = 4'd5;
        for (int i = 0; i < 8; i++) begin
            C_SrcB = mode[i]; D_Imm = imm[i]; D_JImm = jimm[i]; in_valid = 1'b1;
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ext_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (ALU_B !== expb[i]) begin bad++; $display("FAIL ext_b[%0d] got=%h exp=%h", i, ALU_B, expb[i]); end
            total++; if (Store_Data !== 16'h1234) begin bad++; $display("FAIL ext_store[%0d] got=%h exp=1234", i, Store_Data); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_forward();
        set_idle();
        C_SrcA = 2'd1; C_SrcB = 3'd2; D_Imm = 8'h05;
        D_Rs1 = 16'h1111; D_Rs2 = 16'h2222;
        C_Rs1_Addr = 4'd3; C_Rs2_Addr = 4'd3;
        F_ExMem_Wr = 1'b1; F_ExMem_Addr = 4'd3; F_ExMem_Data = 16'hAAAA;
        F_MemWb_Wr = 1'b1; F_MemWb_Addr = 4'd3; F_MemWb_Data = 16'h5555;
        in_valid = 1'b1;
        step();
        total++; if (ALU_A !== 16'hAAAA) begin bad++; $display("FAIL fwd_exmem_a got=%h exp=AAAA", ALU_A); end
        total++; if (Store_Data !== 16'hAAAA) begin bad++; $display("FAIL fwd_exmem_store got=%h exp=AAAA", Store_Data); end
        total++; if (ALU_B !== 16'h0005) begin bad++; $display("FAIL fwd_imm_b got=%h exp=0005", ALU_B); end
        F_ExMem_Wr = 1'b0;
        step();
        total++; if (ALU_A !== 16'h5555) begin bad++; $display("FAIL fwd_memwb_a got=%h exp=5555", ALU_A); end
        total++; if (Store_Data !== 16'h5555) begin bad++; $display("FAIL fwd_memwb_store got=%h exp=5555", Store_Data); end
        F_ExMem_Wr = 1'b1; F_ExMem_Addr = 4'd7; F_MemWb_Addr = 4'd9;
        step();
        total++; if (ALU_A !== 16'h1111) begin bad++; $display("FAIL fwd_nomatch_a got=%h exp=1111", ALU_A); end
        C_Rs1_Addr = 4'd0; C_Rs2_Addr = 4'd0;
        F_ExMem_Addr = 4'd0; F_MemWb_Addr = 4'd0;
        step();
        total++; if (ALU_A !== 16'h1111) begin bad++; $display("FAIL fwd_r0_a got=%h exp=1111", ALU_A); end
        total++; if (Store_Data !== 16'h2222) begin bad++; $display("FAIL fwd_r0_store got=%h exp=2222", Store_Data); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        set_idle();
        C_SrcA = 2'd1; C_SrcB = 3'd0; C_Rs1_Addr = 4'd4; C_Rs2_Addr = 4'd6;
        F_ExMem_Wr = 1'b1; F_ExMem_Addr = 4'd4; F_ExMem_Data = 16'hBEEF;
        D_Rs2 = 16'h0042; in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            F_ExMem_Data = 16'h1000 + 16'(i); D_Rs2 = 16'h2000 + 16'(i);
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (ALU_A !== 16'hBEEF) begin bad++; $display("FAIL stall_a[%0d] got=%h exp=BEEF", i, ALU_A); end
            total++; if (ALU_B !== 16'h0042) begin bad++; $display("FAIL stall_b[%0d] got=%h exp=0042", i, ALU_B); end
        end
        out_ready = 1'b1; F_ExMem_Data = 16'hCAFE; D_Rs2 = 16'h0099;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", out_valid); end
        total++; if (ALU_A !== 16'hCAFE) begin bad++; $display("FAIL release_a got=%h exp=CAFE", ALU_A); end
        total++; if (ALU_B !== 16'h0099) begin bad++; $display("FAIL release_b got=%h exp=0099", ALU_B); end
        step();
    endtask

    task automatic test_flush();
        set_idle();
        C_SrcA = 2'd0; C_SrcB = 3'd1; PC = 16'h1111; in_valid = 1'b1;
        step();
        out_ready = 1'b0; PC = 16'h2222; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped_valid got=%b exp=0", out_valid); end
        total++; if (ALU_A !== 16'h1111) begin bad++; $display("FAIL flush_dropped_a got=%h exp=1111", ALU_A); end
        PC = 16'h3333; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_valid got=%b exp=0", out_valid); end
        total++; if (ALU_A !== 16'h1111) begin bad++; $display("FAIL flush_idle_a got=%h exp=1111", ALU_A); end
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        C_SrcA = 2'd0; C_SrcB = 3'd1; PC = 16'h0ABC; in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
        reset = 1'b1; PC = 16'h0DEF; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_valid got=%b exp=0", out_valid); end
        total++; if (ALU_A !== 16'h0000) begin bad++; $display("FAIL rst_stall_a got=%h exp=0000", ALU_A); end
        total++; if (ALU_B !== 16'h0000) begin bad++; $display("FAIL rst_stall_b got=%h exp=0000", ALU_B); end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_pc_inc();
        test_ext_modes();
        test_forward();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
